// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, states, instruction
// classes, alu_op, branch and trap-cause codes.
package ctrl_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_JAL    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_OP     = 3'd5,
    CLS_IMM    = 3'd6
  } cls_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LINK  = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BLT  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  function automatic logic is_mem_cls(cls_e c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class decoder; purely combinational, zero latency.
// Unlisted opcodes map to CLS_NONE with legal_o low.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_e       cls_o,
  output logic       legal_o
);

  always_comb begin
    cls_o = CLS_NONE;
    case (opcode_i)
      OP_JAL:    cls_o = CLS_JAL;
      OP_LOAD:   cls_o = CLS_LOAD;
      OP_STORE:  cls_o = CLS_STORE;
      OP_BRANCH: cls_o = CLS_BRANCH;
      OP_OP:     cls_o = CLS_OP;
      OP_IMM:    cls_o = CLS_IMM;
      default:   cls_o = CLS_NONE;
    endcase
    legal_o = (cls_o != CLS_NONE);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP); 3-5 cycles per
// instruction, stalls on imem/dmem ready and on en low. PERF_CNT_EN adds cycle/instret counters.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int ILEN        = 32,
  parameter int ALUOP_W     = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ILEN-1:0]    inst,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         branch,
  output logic               is_jal,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic [2:0]         state_o,
  output logic               trap,
  output logic [1:0]         trap_cause
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
`endif
);

  localparam logic [31:0] TO_LIM = 32'(MEM_TIMEOUT);

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d;
  logic                 f3b_q, f3b_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [1:0]           cause_q, cause_d;

  cls_e                 dec_cls;
  logic                 dec_legal;
  logic [TIMEOUT_W-1:0] wait_inc;
  logic                 timeout_hit;

  // Only opcode and funct3[2] steer the control path.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[ILEN-1:15], inst[13:7]};

  ctrl_decode u_decode (
    .opcode_i (inst[6:0]),
    .cls_o    (dec_cls),
    .legal_o  (dec_legal)
  );

  // Saturating increment; timeout fires on the cycle the count would reach the limit.
  always_comb begin
    wait_inc    = (wait_q == '1) ? wait_q : wait_q + TIMEOUT_W'(1);
    timeout_hit = (MEM_TIMEOUT != 0) && (32'(wait_inc) >= TO_LIM);
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    f3b_d   = f3b_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    if (en) begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            state_d = ST_DECODE;
            wait_d  = '0;
          end else if (timeout_hit) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_IMEM_TO;
            wait_d  = '0;
          end else begin
            wait_d = wait_inc;
          end
        end
        ST_DECODE: begin
          if (!dec_legal) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = ST_EXEC;
            cls_d   = dec_cls;
            f3b_d   = inst[14];
          end
        end
        ST_EXEC: begin
          if (is_mem_cls(cls_q))          state_d = ST_MEM;
          else if (cls_q == CLS_BRANCH)   state_d = ST_FETCH;
          else                            state_d = ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
            wait_d  = '0;
          end else if (timeout_hit) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_DMEM_TO;
            wait_d  = '0;
          end else begin
            wait_d = wait_inc;
          end
        end
        ST_WB:   state_d = ST_FETCH;
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_NONE;
      f3b_q   <= 1'b0;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      f3b_q   <= f3b_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Write strobes are qualified by en; requests and selects are not.
  always_comb begin
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch        = BR_NONE;
    is_jal        = 1'b0;
    alu_op        = '0;
    alu_src       = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    trap          = 1'b0;
    trap_cause    = CAUSE_NONE;
    state_o       = ST_FETCH;
    if (!rst) begin
      state_o    = state_q;
      trap_cause = cause_q;
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = en & imem_ready;
          pc_write = en & imem_ready;
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_LOAD, CLS_STORE, CLS_IMM: begin
              alu_src = 1'b1;
              alu_op  = ALUOP_W'(ALU_ADD);
            end
            CLS_OP: alu_op = ALUOP_W'(ALU_FUNCT);
            CLS_BRANCH: begin
              alu_op        = ALUOP_W'(ALU_SUB);
              pc_write_cond = en;
              branch        = f3b_q ? BR_BLT : BR_BEQ;
            end
            CLS_JAL: begin
              alu_src  = 1'b1;
              alu_op   = ALUOP_W'(ALU_LINK);
              pc_write = en;
              is_jal   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_read  = (cls_q == CLS_LOAD);
          mem_write = en & (cls_q == CLS_STORE);
        end
        ST_WB: begin
          reg_write  = en;
          mem_to_reg = (cls_q == CLS_LOAD);
          is_jal     = (cls_q == CLS_JAL);
        end
        ST_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (en && (state_q != ST_TRAP)) cycle_d = cycle_q + 32'd1;
    // Retirement is the return to FETCH from any post-decode state.
    if (en && (state_d == ST_FETCH) &&
        ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)))
      instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected outputs are queued with the stimulus
// and compared as each cycle is driven.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        imem_req, ir_write, pc_write, pc_write_cond, is_jal, alu_src;
  logic        reg_write, mem_read, mem_write, mem_to_reg, trap;
  logic [1:0]  branch, alu_op, trap_cause;
  logic [2:0]  state_o;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .inst(inst),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch(branch), .is_jal(is_jal),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .state_o(state_o), .trap(trap), .trap_cause(trap_cause)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_write, pc_write, pc_write_cond;
    logic [1:0] branch;
    logic       is_jal;
    logic [1:0] alu_op;
    logic       alu_src, reg_write, mem_read, mem_write, mem_to_reg, trap;
    logic [1:0] cause;
  } obs_t;

  typedef struct {
    logic rst, en, ir, dr;
    obs_t e;
  } step_t;

  typedef struct {
    logic [31:0] inst;
    int          iw, dw;
    logic [1:0]  aop;
    logic        asrc;
    logic [1:0]  br;
    logic        pcw, pcwc, jal, mrd, mwr, wb;
  } vec_t;

  step_t sbq[$];
  vec_t  vt[10];
  int    checks = 0;
  int    errors = 0;
  string cur_name;
  obs_t  obs;

  assign obs = {state_o, imem_req, ir_write, pc_write, pc_write_cond, branch, is_jal,
                alu_op, alu_src, reg_write, mem_read, mem_write, mem_to_reg, trap, trap_cause};

  function automatic vec_t mkv(logic [31:0] i, int iw, int dw, logic [1:0] aop, logic asrc,
                               logic [1:0] br, logic pcw, logic pcwc, logic jal,
                               logic mrd, logic mwr, logic wb);
    vec_t v;
    v.inst = i; v.iw = iw; v.dw = dw; v.aop = aop; v.asrc = asrc; v.br = br;
    v.pcw = pcw; v.pcwc = pcwc; v.jal = jal; v.mrd = mrd; v.mwr = mwr; v.wb = wb;
    return v;
  endfunction

  function automatic obs_t idle(logic [2:0] s);
    obs_t o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input logic e, input logic ir, input logic dr, input obs_t o);
    step_t s;
    s.rst = r; s.en = e; s.ir = ir; s.dr = dr; s.e = o;
    sbq.push_back(s);
  endtask

  task automatic push_fetch(input int iw);
    obs_t o = idle(3'd0);
    o.imem_req = 1'b1;
    for (int i = 0; i < iw; i++) push(1'b0, 1'b1, 1'b0, rb(), o);
    o.ir_write = 1'b1;
    o.pc_write = 1'b1;
    push(1'b0, 1'b1, 1'b1, rb(), o);
  endtask

  task automatic push_decode();
    push(1'b0, 1'b1, rb(), rb(), idle(3'd1));
  endtask

  task automatic push_exec(input vec_t v);
    obs_t o = idle(3'd2);
    o.alu_op = v.aop; o.alu_src = v.asrc; o.branch = v.br;
    o.pc_write = v.pcw; o.pc_write_cond = v.pcwc; o.is_jal = v.jal;
    push(1'b0, 1'b1, rb(), rb(), o);
  endtask

  task automatic push_mem_wait(input vec_t v, input int n);
    obs_t o = idle(3'd3);
    o.mem_read = v.mrd; o.mem_write = v.mwr;
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, rb(), 1'b0, o);
  endtask

  task automatic push_instr(input vec_t v);
    obs_t o;
    push_fetch(v.iw);
    push_decode();
    push_exec(v);
    if (v.mrd || v.mwr) begin
      push_mem_wait(v, v.dw);
      o = idle(3'd3);
      o.mem_read = v.mrd; o.mem_write = v.mwr;
      push(1'b0, 1'b1, rb(), 1'b1, o);
    end
    if (v.wb) begin
      o = idle(3'd4);
      o.reg_write = 1'b1; o.mem_to_reg = v.mrd; o.is_jal = v.jal;
      push(1'b0, 1'b1, rb(), rb(), o);
    end
  endtask

  function automatic obs_t trap_obs(logic [1:0] c);
    obs_t o = idle(3'd7);
    o.trap = 1'b1;
    o.cause = c;
    return o;
  endfunction

  // Reset cycle (all outputs 0), then one held FETCH cycle with a stray ready that must be ignored.
  task automatic push_reset_tail();
    obs_t o = idle(3'd0);
    o.imem_req = 1'b1;
    push(1'b1, rb(), rb(), rb(), '0);
    push(1'b0, 1'b0, 1'b1, rb(), o);
  endtask

  task automatic drain();
    step_t s;
    int k = 0;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      @(negedge clk);
      rst = s.rst; en = s.en; imem_ready = s.ir; dmem_ready = s.dr;
      #1;
      checks++;
      if (obs !== s.e) begin
        errors++;
        $display("FAIL %s step %0d: got %05h required %05h", cur_name, k, obs, s.e);
      end
      k++;
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    logic [31:0] cyc0, ret0;
    cyc0 = '0;
    ret0 = '0;
    //            inst          iw dw aop  src br   pcw pcwc jal mrd mwr wb
    vt[0] = mkv(32'h00000033, 0, 0, 2'd2, 0, 2'd0, 0, 0, 0, 0, 0, 1); // add
    vt[1] = mkv(32'h00002003, 0, 3, 2'd0, 1, 2'd0, 0, 0, 0, 1, 0, 1); // lw, 3 dmem waits
    vt[2] = mkv(32'h00004063, 0, 0, 2'd1, 0, 2'd2, 0, 1, 0, 0, 0, 0); // blt
    vt[3] = mkv(32'h00000063, 1, 0, 2'd1, 0, 2'd1, 0, 1, 0, 0, 0, 0); // beq
    vt[4] = mkv(32'h00002023, 2, 1, 2'd0, 1, 2'd0, 0, 0, 0, 0, 1, 0); // sw
    vt[5] = mkv(32'h00100093, 3, 0, 2'd0, 1, 2'd0, 0, 0, 0, 0, 0, 1); // addi, 3 imem waits
    vt[6] = mkv(32'h0000006F, 0, 0, 2'd3, 1, 2'd0, 1, 0, 1, 0, 0, 1); // jal
    vt[7] = mkv(32'h00002003, 0, 0, 2'd0, 1, 2'd0, 0, 0, 0, 1, 0, 1); // lw, no waits
    vt[8] = mkv(32'h40000033, 0, 0, 2'd2, 0, 2'd0, 0, 0, 0, 0, 0, 1); // sub
    vt[9] = mkv(32'h00002023, 0, 3, 2'd0, 1, 2'd0, 0, 0, 0, 0, 1, 0); // sw, 3 dmem waits

    cur_name = "reset";
    push(1'b1, 1'b1, 1'b1, 1'b1, '0);
    push(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drain();
`ifdef PERF_CNT_EN
    check32("cycle_cnt_reset", cycle_cnt, 32'd0);
    check32("instret_cnt_reset", instret_cnt, 32'd0);
`endif
    cur_name = "reset_exit";
    o = idle(3'd0);
    o.imem_req = 1'b1;
    push(1'b0, 1'b0, 1'b1, 1'b1, o);
    drain();

    for (int i = 0; i < 10; i++) begin
      cur_name = $sformatf("vec%0d", i);
      inst = vt[i].inst;
      push_instr(vt[i]);
      drain();
    end

    cur_name = "jal_stall";
    inst = vt[6].inst;
    o = idle(3'd0);
    o.imem_req = 1'b1;
    push(1'b0, 1'b0, 1'b1, rb(), o);
    drain();
`ifdef PERF_CNT_EN
    cyc0 = cycle_cnt;
    ret0 = instret_cnt;
`endif
    push_fetch(0);
    push_decode();
    push_exec(vt[6]);
    o = idle(3'd4);
    o.is_jal = 1'b1;
    push(1'b0, 1'b0, rb(), rb(), o);
    push(1'b0, 1'b0, rb(), rb(), o);
    o.reg_write = 1'b1;
    push(1'b0, 1'b1, rb(), rb(), o);
    o = idle(3'd0);
    o.imem_req = 1'b1;
    push(1'b0, 1'b0, 1'b1, rb(), o);
    drain();
`ifdef PERF_CNT_EN
    check32("instret_jal_delta", instret_cnt - ret0, 32'd1);
    check32("cycle_jal_delta", cycle_cnt - cyc0, 32'd4);
`endif

    cur_name = "sw_timeout";
    inst = vt[4].inst;
    push_fetch(0);
    push_decode();
    push_exec(vt[4]);
    push_mem_wait(vt[4], 4);
    for (int i = 0; i < 3; i++) push(1'b0, rb(), 1'b1, 1'b1, trap_obs(2'b11));
    push_reset_tail();
    drain();

    cur_name = "sw_rst_wait";
    push_fetch(0);
    push_decode();
    push_exec(vt[4]);
    push_mem_wait(vt[4], 2);
    push_reset_tail();
    drain();

    cur_name = "imem_timeout";
    o = idle(3'd0);
    o.imem_req = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 1'b0, rb(), o);
    for (int i = 0; i < 2; i++) push(1'b0, 1'b1, 1'b1, 1'b1, trap_obs(2'b10));
    push_reset_tail();
    drain();

    cur_name = "illegal";
    inst = 32'h0000007F;
    push_fetch(0);
    push_decode();
    for (int i = 0; i < 3; i++) push(1'b0, rb(), 1'b1, 1'b1, trap_obs(2'b01));
    push_reset_tail();
    drain();

    cur_name = "recover_add";
    inst = vt[0].inst;
    push_instr(vt[0]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
